sample_framer: RTL
==================

Name: sample_framer

Overview:
- Upstream stage of the DTW sample FIFO; produces the FIFO's `data`/`wrreq` pair.
- Receives raw 16-bit signed ADC samples and decimates them by 2^LOG2_DECIM, using a block average with rounding.
- Writes decimated samples into the FIFO in frames of FRAME_LEN words.
- After each frame it stops writing and waits until the downstream consumer has drained the FIFO, so the DTW processor always sees whole frames.

Parameters:
- WORD, 16, sample width (input and output).
- LOG2_DECIM, 2, decimation factor N = 2^LOG2_DECIM (0 means pass-through).
- FRAME_LEN, 64, decimated samples per frame (1..127, must fit the FIFO).
- CNT_W, 16, width of the dropped-sample counter.

Ports:
- clk  in  1  system clock.
- rst_geral  in  1  asynchronous reset, active-low.
- enable  in  1  level; 1 = acquire, 0 = abort/idle.
- adc_data  in  WORD  signed ADC sample.
- adc_valid  in  1  adc_data valid this cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- data  out  WORD  signed decimated sample to FIFO.
- wrreq  out  1  one-cycle FIFO write strobe.
- frame_done  out  1  one-cycle pulse when the last word of a frame is written.
- busy  out  1  high in ACC or WAIT_DRAIN.
- overflow  out  1  sticky; set when a push is attempted while fifo_full=1.
- dropped  out  CNT_W  count of decimated samples lost to fifo_full (saturating).

Behaviour:
- Reset (rst_geral=0, asynchronous): every output is 0. This covers data, wrreq, frame_done, busy, overflow and dropped. Also cleared: the accumulator, the sub-sample counter (0..N-1), the frame counter (0..FRAME_LEN-1), and the state (IDLE).
- States:
  - IDLE: wait for enable=1, then go to ACC with accumulator and counters cleared.
  - ACC: on each adc_valid, accumulate sign-extended adc_data into a (WORD+LOG2_DECIM)-bit register.
    - When adc_valid arrives with sub-counter = N-1, compute avg = (acc + adc_data + 2^(LOG2_DECIM-1)) >>> LOG2_DECIM, an arithmetic shift. Use no rounding term when LOG2_DECIM=0.
    - Then clear the accumulator and sub-counter, and go to PUSH.
    - adc_valid in the cycle after completion starts the next block; no samples are lost.
  - PUSH (1 cycle, also accumulates any adc_valid):
    - If fifo_full=0: wrreq=1 and data=avg, both registered, so wrreq appears the cycle after the completing adc_valid. Frame counter increments.
    - If fifo_full=1: wrreq=0, overflow<=1, dropped increments (saturating at all-ones), and the frame counter still increments.
    - If the frame counter was FRAME_LEN-1: frame_done=1 in the same cycle as the final wrreq (or the final drop), the frame counter clears, and the next state is WAIT_DRAIN. Otherwise return to ACC.
  - WAIT_DRAIN: adc_valid is ignored and the accumulator is held at 0. Leave when fifo_empty=1: go to ACC if enable=1, else IDLE.
- enable=0 in ACC or PUSH: go to IDLE next cycle.
  - The partial block and partial frame are discarded.
  - A PUSH in progress still completes its write that cycle.
  - overflow and dropped are kept; only reset clears them.
- enable=0 in WAIT_DRAIN: stay until fifo_empty=1, then go to IDLE.
- wrreq is never high in two consecutive cycles (N≥2); with N=1, back-to-back pushes are allowed.
- data holds its last written value when wrreq=0.
- Arithmetic: signed two's complement throughout. The average cannot exceed WORD range, so no saturation is needed.

Optional Feature:
- Macro: SAMPLE_FRAMER_DC_REMOVE_EN.
- Defined:
  - A DC-estimate register dc (WORD+8 bits, fractional) updates on every push (or drop): dc <= dc + ((avg<<<8) - dc) >>> 6.
  - data = sat_WORD(avg - (dc>>>8)), where sat_WORD saturates to ±(2^(WORD-1)-1 / -2^(WORD-1)).
  - dc uses its value from before the update. It resets to 0 and is not cleared on enable=0.
- Undefined: data = avg, and no dc register exists.

Test Plan:
- Reset, LOG2_DECIM=2: samples 1,2,3,4 with adc_valid each cycle. Required: wrreq one cycle after the 4th sample, data=3 (10+2=12, >>>2 = 3).
- Samples -1,-1,-2,-2 (sum -6, +2 = -4, >>>2 = -1). Required: data=-1. Samples 32767×4 give data=32767; -32768×4 give data=-32768.
- FRAME_LEN=4, continuous input, fifo_empty=0. Required:
  - exactly 4 wrreq, with frame_done together with the 4th;
  - further adc_valid produce no wrreq;
  - after fifo_empty=1, the next wrreq comes from the 4 samples after re-entry to ACC.
- fifo_full=1 during 3 consecutive PUSH cycles. Required: wrreq stays 0, overflow=1, dropped=3, and the frame count still advances.
- enable=0 after 2 of 4 samples, then enable=1 and samples 8,8,8,8. Required: data=8, with no contamination from the partial block.
- Assert rst_geral=0 mid-frame, asynchronously between clock edges. Required: all outputs 0 immediately; after release, IDLE until enable=1.

Source files
------------

// File: rtl/sample_framer.sv
// Decimating block-average framer feeding the DTW sample FIFO in whole frames.
// Optional DC removal on the output path is built when SAMPLE_FRAMER_DC_REMOVE_EN is defined.
module sample_framer #(
  parameter int WORD       = 16,
  parameter int LOG2_DECIM = 2,
  parameter int FRAME_LEN  = 64,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_geral,
  input  logic              enable,
  input  logic [WORD-1:0]   adc_data,
  input  logic              adc_valid,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  output logic [WORD-1:0]   data,
  output logic              wrreq,
  output logic              frame_done,
  output logic              busy,
  output logic              overflow,
  output logic [CNT_W-1:0]  dropped
);

  localparam int N   = 1 << LOG2_DECIM;
  localparam int SW  = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam int AW  = WORD + LOG2_DECIM + 1;
  localparam int FW  = 7;
  localparam int RND = N >> 1;
  localparam logic signed [AW-1:0] RND_C = AW'(RND);

  typedef enum logic [1:0] {IDLE, ACC, PUSH, WAIT_DRAIN} state_t;

  state_t                  state_reg;
  logic signed [AW-1:0]    acc_reg;
  logic [SW-1:0]           sub_reg;
  logic [FW-1:0]           frame_reg;
  logic [WORD-1:0]         data_reg;
  logic                    wrreq_reg;
  logic                    frame_done_reg;
  logic                    busy_reg;
  logic                    overflow_reg;
  logic [CNT_W-1:0]        dropped_reg;

  logic signed [AW-1:0]    sample_ext;
  logic signed [AW-1:0]    sum_c;
  logic signed [WORD-1:0]  avg_c;
  logic [WORD-1:0]         data_c;
  logic                    last_sub;
  logic                    frame_last;

  assign sample_ext = {{(AW-WORD){adc_data[WORD-1]}}, adc_data};
  assign sum_c      = acc_reg + sample_ext + RND_C;
  assign avg_c      = WORD'(sum_c >>> LOG2_DECIM);
  assign last_sub   = (sub_reg == SW'(N-1));
  assign frame_last = (frame_reg == FW'(FRAME_LEN-1));

`ifdef SAMPLE_FRAMER_DC_REMOVE_EN
  localparam int DW = WORD + 8;
  localparam logic [WORD-1:0] SAT_MAX = {1'b0, {(WORD-1){1'b1}}};
  localparam logic [WORD-1:0] SAT_MIN = {1'b1, {(WORD-1){1'b0}}};

  // dc carries 8 fractional bits; the output uses the estimate from before this push
  logic signed [DW-1:0]    dc_reg;
  logic signed [DW+1:0]    dc_err_c;
  logic signed [DW+1:0]    dc_step_c;
  logic signed [WORD:0]    dc_diff_c;

  assign dc_err_c  = {{2{avg_c[WORD-1]}}, avg_c, 8'd0} - {{2{dc_reg[DW-1]}}, dc_reg};
  assign dc_step_c = dc_err_c >>> 6;
  assign dc_diff_c = {avg_c[WORD-1], avg_c} - {dc_reg[DW-1], dc_reg[DW-1:8]};

  always_comb begin
    data_c = dc_diff_c[WORD-1:0];
    if (dc_diff_c[WORD] != dc_diff_c[WORD-1])
      data_c = dc_diff_c[WORD] ? SAT_MIN : SAT_MAX;
  end

  always_ff @(posedge clk or negedge rst_geral) begin
    if (!rst_geral)
      dc_reg <= '0;
    else if ((state_reg == ACC || (state_reg == PUSH && !frame_done_reg)) &&
             enable && adc_valid && last_sub)
      dc_reg <= dc_reg + DW'(dc_step_c);
  end
`else
  assign data_c = avg_c;
`endif

  always_ff @(posedge clk or negedge rst_geral) begin
    if (!rst_geral) begin
      state_reg      <= IDLE;
      acc_reg        <= '0;
      sub_reg        <= '0;
      frame_reg      <= '0;
      data_reg       <= '0;
      wrreq_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      busy_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
      dropped_reg    <= '0;
    end else begin
      wrreq_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          busy_reg <= enable;
          if (enable) begin
            state_reg <= ACC;
            acc_reg   <= '0;
            sub_reg   <= '0;
            frame_reg <= '0;
          end
        end
        ACC, PUSH: begin
          busy_reg <= enable;
          if (!enable) begin
            // abort drops the partial block and frame; a registered write already went out
            state_reg <= IDLE;
            acc_reg   <= '0;
            sub_reg   <= '0;
            frame_reg <= '0;
          end else if (state_reg == PUSH && frame_done_reg) begin
            state_reg <= WAIT_DRAIN;
            acc_reg   <= '0;
            sub_reg   <= '0;
          end else if (adc_valid) begin
            if (last_sub) begin
              state_reg      <= PUSH;
              acc_reg        <= '0;
              sub_reg        <= '0;
              frame_done_reg <= frame_last;
              frame_reg      <= frame_last ? '0 : frame_reg + 7'd1;
              if (!fifo_full) begin
                wrreq_reg <= 1'b1;
                data_reg  <= data_c;
              end else begin
                overflow_reg <= 1'b1;
                if (!(&dropped_reg))
                  dropped_reg <= dropped_reg + CNT_W'(1);
              end
            end else begin
              state_reg <= ACC;
              acc_reg   <= acc_reg + sample_ext;
              sub_reg   <= sub_reg + SW'(1);
            end
          end else begin
            state_reg <= ACC;
          end
        end
        WAIT_DRAIN: begin
          acc_reg  <= '0;
          sub_reg  <= '0;
          busy_reg <= !(fifo_empty && !enable);
          if (fifo_empty)
            state_reg <= enable ? ACC : IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign data       = data_reg;
  assign wrreq      = wrreq_reg;
  assign frame_done = frame_done_reg;
  assign busy       = busy_reg;
  assign overflow   = overflow_reg;
  assign dropped    = dropped_reg;

endmodule
